pipe_hazard_ctrl: RTL and testbench

Control-sideband pipeline for the ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage core. It carries register addresses, write enables and opcodes down the pipe and drives the EX/MEM/WB-side inputs of the forwarding unit. It also detects the load-use hazard that forwarding cannot resolve, squashes the instruction in ID on a taken branch, and keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Control-sideband pipeline for the ID/EX, EX/MEM and MEM/WB stage registers
// of the 5-stage core. It carries register addresses, write enables and
// opcodes down the pipe and feeds the EX/MEM/WB-side inputs of the
// forwarding unit. It also:
//   - detects the load-use hazard that forwarding cannot resolve,
//   - squashes the instruction in ID on a taken branch, and
//   - keeps saturating stall and flush counters for performance debug.
//
// Parameters:
//   RSIZE  register-address width
//   OPW    opcode width
//   CW     event-counter width
//
// Ports:
//   clk                      clock, rising-edge active
//   rst_n                    asynchronous active-low reset
//   ID_Valid                 IF/ID holds a real instruction
//   ID_RAddr1/ID_RAddr2      source registers of the ID instruction
//   ID_WAddr                 destination register of the ID instruction
//   ID_RFWen                 ID instruction writes the register file
//   ID_opCode                ID opcode
//   BranchTaken              branch in EX resolved taken (combinational)
//   RAddr1/RAddr2            EX-stage source registers
//   EX_WAddr/EX_RFWen/EX_opCode              EX-stage sideband
//   MEM_RAddr2/MEM_WAddr/MEM_RFWen/MEM_opCode MEM-stage sideband
//   WB_WAddr/WB_RFWen        WB-stage sideband
//   Stall                    hold PC and IF/ID this cycle (combinational)
//   IF_Flush                 clear IF/ID at this edge (combinational)
//   StallCnt/FlushCnt        saturating event counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned RSIZE = 4,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             ID_Valid,
    input  logic [RSIZE-1:0] ID_RAddr1,
    input  logic [RSIZE-1:0] ID_RAddr2,
    input  logic [RSIZE-1:0] ID_WAddr,
    input  logic             ID_RFWen,
    input  logic [OPW-1:0]   ID_opCode,
    input  logic             BranchTaken,

    output logic [RSIZE-1:0] RAddr1,
    output logic [RSIZE-1:0] RAddr2,
    output logic [RSIZE-1:0] EX_WAddr,
    output logic             EX_RFWen,
    output logic [OPW-1:0]   EX_opCode,

    output logic [RSIZE-1:0] MEM_RAddr2,
    output logic [RSIZE-1:0] MEM_WAddr,
    output logic             MEM_RFWen,
    output logic [OPW-1:0]   MEM_opCode,

    output logic [RSIZE-1:0] WB_WAddr,
    output logic             WB_RFWen,

    output logic             Stall,
    output logic             IF_Flush,
    output logic [CW-1:0]    StallCnt,
    output logic [CW-1:0]    FlushCnt
);

    localparam logic [OPW-1:0] OP_LW = OPW'(8);
    localparam logic [OPW-1:0] OP_SW = OPW'(9);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [RSIZE-1:0] ex_raddr1_q,  ex_raddr1_d;
    logic [RSIZE-1:0] ex_raddr2_q,  ex_raddr2_d;
    logic [RSIZE-1:0] ex_waddr_q,   ex_waddr_d;
    logic             ex_rfwen_q,   ex_rfwen_d;
    logic [OPW-1:0]   ex_op_q,      ex_op_d;

    logic [RSIZE-1:0] mem_raddr2_q, mem_raddr2_d;
    logic [RSIZE-1:0] mem_waddr_q,  mem_waddr_d;
    logic             mem_rfwen_q,  mem_rfwen_d;
    logic [OPW-1:0]   mem_op_q,     mem_op_d;

    logic [RSIZE-1:0] wb_waddr_q,   wb_waddr_d;
    logic             wb_rfwen_q,   wb_rfwen_d;

    logic [CW-1:0]    stall_cnt_q,  stall_cnt_d;
    logic [CW-1:0]    flush_cnt_q,  flush_cnt_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic ex_is_load;
    logic match_rs1;
    logic match_rs2;
    logic load_use;
    logic stall;
    logic ex_bubble;

    always_comb begin
        // A load to r0 never produces a value anyone waits on.
        ex_is_load = (ex_op_q == OP_LW) && ex_rfwen_q && (ex_waddr_q != '0);
        match_rs1  = (ex_waddr_q == ID_RAddr1);
        // RAddr2 of a store is the data register; WB->MEM forwarding
        // covers it, so only the base register can force a stall.
        match_rs2  = (ex_waddr_q == ID_RAddr2) && (ID_opCode != OP_SW);
        load_use   = ID_Valid && ex_is_load && (match_rs1 || match_rs2);
        // A taken branch squashes the dependent instruction anyway.
        stall      = load_use && !BranchTaken;
        ex_bubble  = stall || BranchTaken || !ID_Valid;
    end

    // ------------------------------------------------------------------
    // Next-state: stage registers
    // ------------------------------------------------------------------
    always_comb begin
        ex_raddr1_d = '0;
        ex_raddr2_d = '0;
        ex_waddr_d  = '0;
        ex_rfwen_d  = 1'b0;
        ex_op_d     = '0;
        if (!ex_bubble) begin
            ex_raddr1_d = ID_RAddr1;
            ex_raddr2_d = ID_RAddr2;
            ex_waddr_d  = ID_WAddr;
            ex_rfwen_d  = ID_RFWen;
            ex_op_d     = ID_opCode;
        end
    end

    // Downstream stages never hold: a stall only inserts a bubble in EX.
    always_comb begin
        mem_raddr2_d = ex_raddr2_q;
        mem_waddr_d  = ex_waddr_q;
        mem_rfwen_d  = ex_rfwen_q;
        mem_op_d     = ex_op_q;
        wb_waddr_d   = mem_waddr_q;
        wb_rfwen_d   = mem_rfwen_q;
    end

    // ------------------------------------------------------------------
    // Next-state: saturating event counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
        if (BranchTaken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_raddr1_q  <= '0;
            ex_raddr2_q  <= '0;
            ex_waddr_q   <= '0;
            ex_rfwen_q   <= 1'b0;
            ex_op_q      <= '0;
            mem_raddr2_q <= '0;
            mem_waddr_q  <= '0;
            mem_rfwen_q  <= 1'b0;
            mem_op_q     <= '0;
            wb_waddr_q   <= '0;
            wb_rfwen_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_raddr1_q  <= ex_raddr1_d;
            ex_raddr2_q  <= ex_raddr2_d;
            ex_waddr_q   <= ex_waddr_d;
            ex_rfwen_q   <= ex_rfwen_d;
            ex_op_q      <= ex_op_d;
            mem_raddr2_q <= mem_raddr2_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_rfwen_q  <= mem_rfwen_d;
            mem_op_q     <= mem_op_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_rfwen_q   <= wb_rfwen_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        RAddr1     = ex_raddr1_q;
        RAddr2     = ex_raddr2_q;
        EX_WAddr   = ex_waddr_q;
        EX_RFWen   = ex_rfwen_q;
        EX_opCode  = ex_op_q;
        MEM_RAddr2 = mem_raddr2_q;
        MEM_WAddr  = mem_waddr_q;
        MEM_RFWen  = mem_rfwen_q;
        MEM_opCode = mem_op_q;
        WB_WAddr   = wb_waddr_q;
        WB_RFWen   = wb_rfwen_q;
        Stall      = stall;
        IF_Flush   = BranchTaken;
        StallCnt   = stall_cnt_q;
        FlushCnt   = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl (instantiated with CW=4 so counter
// saturation is reachable). A table of per-cycle vectors drives the ID-side
// inputs; before each edge the combinational Stall/IF_Flush are checked,
// after the edge the EX/MEM/WB sideband and counters are checked. Hand
// sequences cover reset with random inputs, counter saturation and reset
// asserted during a stall.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int unsigned RSIZE = 4;
    localparam int unsigned OPW   = 4;
    localparam int unsigned CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             ID_Valid;
    logic [RSIZE-1:0] ID_RAddr1, ID_RAddr2, ID_WAddr;
    logic             ID_RFWen;
    logic [OPW-1:0]   ID_opCode;
    logic             BranchTaken;
    logic [RSIZE-1:0] RAddr1, RAddr2, EX_WAddr;
    logic             EX_RFWen;
    logic [OPW-1:0]   EX_opCode;
    logic [RSIZE-1:0] MEM_RAddr2, MEM_WAddr;
    logic             MEM_RFWen;
    logic [OPW-1:0]   MEM_opCode;
    logic [RSIZE-1:0] WB_WAddr;
    logic             WB_RFWen;
    logic             Stall, IF_Flush;
    logic [CW-1:0]    StallCnt, FlushCnt;

    pipe_hazard_ctrl #(.RSIZE(RSIZE), .OPW(OPW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ID_Valid   (ID_Valid),
        .ID_RAddr1  (ID_RAddr1),
        .ID_RAddr2  (ID_RAddr2),
        .ID_WAddr   (ID_WAddr),
        .ID_RFWen   (ID_RFWen),
        .ID_opCode  (ID_opCode),
        .BranchTaken(BranchTaken),
        .RAddr1     (RAddr1),
        .RAddr2     (RAddr2),
        .EX_WAddr   (EX_WAddr),
        .EX_RFWen   (EX_RFWen),
        .EX_opCode  (EX_opCode),
        .MEM_RAddr2 (MEM_RAddr2),
        .MEM_WAddr  (MEM_WAddr),
        .MEM_RFWen  (MEM_RFWen),
        .MEM_opCode (MEM_opCode),
        .WB_WAddr   (WB_WAddr),
        .WB_RFWen   (WB_RFWen),
        .Stall      (Stall),
        .IF_Flush   (IF_Flush),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        // inputs
        int v, a1, a2, wa, we, op, br;
        // expected: combinational before the edge
        int stall, flush;
        // expected: registered after the edge
        int ex_a1, ex_a2, ex_wa, ex_we, ex_op;
        int mem_wa, mem_op;
        int wb_wa, wb_we;
        int scnt, fcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int v, a1, a2, wa, we, op, br,
                       input int stall, flush,
                       input int ex_a1, ex_a2, ex_wa, ex_we, ex_op,
                       input int mem_wa, mem_op, wb_wa, wb_we, scnt, fcnt);
        vec_t t;
        t.v = v; t.a1 = a1; t.a2 = a2; t.wa = wa; t.we = we; t.op = op; t.br = br;
        t.stall = stall; t.flush = flush;
        t.ex_a1 = ex_a1; t.ex_a2 = ex_a2; t.ex_wa = ex_wa; t.ex_we = ex_we; t.ex_op = ex_op;
        t.mem_wa = mem_wa; t.mem_op = mem_op; t.wb_wa = wb_wa; t.wb_we = wb_we;
        t.scnt = scnt; t.fcnt = fcnt;
        vecs.push_back(t);
    endtask

    task automatic drive(input int v, a1, a2, wa, we, op, br);
        ID_Valid    = v[0];
        ID_RAddr1   = RSIZE'(a1);
        ID_RAddr2   = RSIZE'(a2);
        ID_WAddr    = RSIZE'(wa);
        ID_RFWen    = we[0];
        ID_opCode   = OPW'(op);
        BranchTaken = br[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_RAddr1"},     int'(RAddr1), 0);
        chk({tag, "_RAddr2"},     int'(RAddr2), 0);
        chk({tag, "_EX_WAddr"},   int'(EX_WAddr), 0);
        chk({tag, "_EX_RFWen"},   int'(EX_RFWen), 0);
        chk({tag, "_EX_opCode"},  int'(EX_opCode), 0);
        chk({tag, "_MEM_RAddr2"}, int'(MEM_RAddr2), 0);
        chk({tag, "_MEM_WAddr"},  int'(MEM_WAddr), 0);
        chk({tag, "_MEM_RFWen"},  int'(MEM_RFWen), 0);
        chk({tag, "_MEM_opCode"}, int'(MEM_opCode), 0);
        chk({tag, "_WB_WAddr"},   int'(WB_WAddr), 0);
        chk({tag, "_WB_RFWen"},   int'(WB_RFWen), 0);
        chk({tag, "_Stall"},      int'(Stall), 0);
        chk({tag, "_IF_Flush"},   int'(IF_Flush), 0);
        chk({tag, "_StallCnt"},   int'(StallCnt), 0);
        chk({tag, "_FlushCnt"},   int'(FlushCnt), 0);
    endtask

    initial begin
        int nstalls;
        int prev_fcnt;

        //      v a1 a2 wa we op br | st fl | ex a1 a2 wa we op | mem wa op | wb wa we | scnt fcnt
        add(1, 1, 1, 3, 1, 0, 0,   0, 0,   1, 1, 3, 1, 0,   0, 0,   0, 0,   0, 0); // ADD r3
        add(0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0,   3, 0,   0, 0,   0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0,   0, 0,   3, 1,   0, 0);
        add(1, 1, 0, 2, 1, 8, 0,   0, 0,   1, 0, 2, 1, 8,   0, 0,   0, 0,   0, 0); // LW r2
        add(1, 2, 1, 4, 1, 0, 0,   1, 0,   0, 0, 0, 0, 0,   2, 8,   0, 0,   1, 0); // use r2: stall
        add(1, 2, 1, 4, 1, 0, 0,   0, 0,   2, 1, 4, 1, 0,   0, 0,   2, 1,   1, 0); // advances
        add(1, 1, 0, 5, 1, 8, 0,   0, 0,   1, 0, 5, 1, 8,   4, 0,   0, 0,   1, 0); // LW r5
        add(1, 1, 5, 0, 0, 9, 0,   0, 0,   1, 5, 0, 0, 9,   5, 8,   4, 1,   1, 0); // SW data r5: no stall
        add(1, 1, 0, 5, 1, 8, 0,   0, 0,   1, 0, 5, 1, 8,   0, 9,   5, 1,   1, 0); // LW r5
        add(1, 5, 1, 0, 0, 9, 0,   1, 0,   0, 0, 0, 0, 0,   5, 8,   0, 0,   2, 0); // SW base r5: stall
        add(1, 5, 1, 0, 0, 9, 0,   0, 0,   5, 1, 0, 0, 9,   0, 0,   5, 1,   2, 0);
        add(1, 1, 0, 0, 1, 8, 0,   0, 0,   1, 0, 0, 1, 8,   0, 9,   0, 0,   2, 0); // LW r0
        add(1, 0, 0, 6, 1, 0, 0,   0, 0,   0, 0, 6, 1, 0,   0, 8,   0, 0,   2, 0); // use r0: no stall
        add(0, 1, 0, 2, 1, 8, 0,   0, 0,   0, 0, 0, 0, 0,   6, 0,   0, 1,   2, 0); // invalid LW -> bubble
        add(1, 1, 0, 2, 1, 8, 0,   0, 0,   1, 0, 2, 1, 8,   0, 0,   6, 1,   2, 0); // LW r2
        add(1, 2, 0, 7, 1, 0, 1,   0, 1,   0, 0, 0, 0, 0,   2, 8,   0, 0,   2, 1); // hazard + branch
        add(0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0, 0, 0, 0,   0, 0,   2, 1,   2, 1);
        add(1, 1, 0, 2, 1, 8, 0,   0, 0,   1, 0, 2, 1, 8,   0, 0,   0, 0,   2, 1); // LW r2
        add(1, 2, 0, 3, 1, 8, 0,   1, 0,   0, 0, 0, 0, 0,   2, 8,   0, 0,   3, 1); // LW r3 uses r2
        add(1, 2, 0, 3, 1, 8, 0,   0, 0,   2, 0, 3, 1, 8,   0, 0,   2, 1,   3, 1);
        add(1, 1, 3, 4, 1, 0, 0,   1, 0,   0, 0, 0, 0, 0,   3, 8,   0, 0,   4, 1); // use r3 via RAddr2
        add(1, 1, 3, 4, 1, 0, 0,   0, 0,   1, 3, 4, 1, 0,   0, 0,   3, 1,   4, 1);

        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), int'($urandom_range(7, 10)),
                  int'($urandom_range(0, 1)));
            tick();
        end
        @(negedge clk);
        BranchTaken = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            string s;
            s = $sformatf("v%0d", i);
            drive(vecs[i].v, vecs[i].a1, vecs[i].a2, vecs[i].wa,
                  vecs[i].we, vecs[i].op, vecs[i].br);
            #1;
            chk({s, "_Stall"},    int'(Stall),      vecs[i].stall);
            chk({s, "_IF_Flush"}, int'(IF_Flush),   vecs[i].flush);
            tick();
            chk({s, "_RAddr1"},   int'(RAddr1),     vecs[i].ex_a1);
            chk({s, "_RAddr2"},   int'(RAddr2),     vecs[i].ex_a2);
            chk({s, "_EX_WAddr"}, int'(EX_WAddr),   vecs[i].ex_wa);
            chk({s, "_EX_RFWen"}, int'(EX_RFWen),   vecs[i].ex_we);
            chk({s, "_EX_op"},    int'(EX_opCode),  vecs[i].ex_op);
            chk({s, "_MEM_WAddr"},int'(MEM_WAddr),  vecs[i].mem_wa);
            chk({s, "_MEM_op"},   int'(MEM_opCode), vecs[i].mem_op);
            chk({s, "_WB_WAddr"}, int'(WB_WAddr),   vecs[i].wb_wa);
            chk({s, "_WB_RFWen"}, int'(WB_RFWen),   vecs[i].wb_we);
            chk({s, "_StallCnt"}, int'(StallCnt),   vecs[i].scnt);
            chk({s, "_FlushCnt"}, int'(FlushCnt),   vecs[i].fcnt);
        end
        // RAddr2 of the last ADD (3) has reached MEM one edge later
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("mem_raddr2", int'(MEM_RAddr2), 3);

        // ---------------- stall counter saturation ----------------
        // Holding "LW r2 <- [r2]" in ID stalls on every other cycle.
        prev_fcnt = int'(FlushCnt);
        nstalls = 0;
        drive(1, 2, 0, 2, 1, 8, 0);
        for (int i = 0; i < 41; i++) begin
            #1;
            if (Stall) nstalls++;
            tick();
        end
        chk("sat_stall_events", nstalls, 20);
        chk("sat_StallCnt", int'(StallCnt), 15);
        chk("sat_FlushCnt", int'(FlushCnt), prev_fcnt);

        // ---------------- reset asserted mid-stall ----------------
        drive(1, 1, 0, 2, 1, 8, 0);   // LW r2 into EX
        tick();
        drive(1, 2, 1, 4, 1, 0, 0);   // dependent ADD
        #1;
        chk("midrst_pre_Stall", int'(Stall), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_post_RAddr1", int'(RAddr1), 2);
        chk("midrst_post_EX_WAddr", int'(EX_WAddr), 4);
        chk("midrst_post_StallCnt", int'(StallCnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the stimulus above is finite, this only guards against hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
